fp_addsub_pipe: RTL and testbench

FP_ADDSUB_PIPE -- requirements
Module: fp_addsub_pipe

---
 rtl/fp_pkg.sv | 18 +
 rtl/fp_lzc.sv | 17 +
 rtl/fp_addsub_pipe.sv | 184 ++++++++++++++++++
 tb/tb_fp_addsub_pipe.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fp_pkg.sv
// rtl/fp_pkg.sv - shared widths, flag bit indices and unpacked operand type for fp_addsub_pipe
package fp_pkg;

    localparam int EXP_W_DEF = 8;
    localparam int MAN_W_DEF = 23;

    localparam int FLAG_ZERO = 0;
    localparam int FLAG_UNF  = 1;
    localparam int FLAG_OVF  = 2;

    // Default-width operand view; mant carries the hidden bit at its MSB.
    typedef struct packed {
        logic                 sign;
        logic [EXP_W_DEF-1:0] exp;
        logic [MAN_W_DEF:0]   mant;
    } fp_unpacked_t;

endpackage

// File: rtl/fp_lzc.sv
// rtl/fp_lzc.sv - leading-zero counter; returns WIDTH for an all-zero input
module fp_lzc #(
    parameter int WIDTH = 27,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic [WIDTH-1:0] i_data,
    output logic [CNT_W-1:0] o_count
);

    always_comb begin
        o_count = CNT_W'(WIDTH);
        for (int i = 0; i < WIDTH; i++) begin
            if (i_data[i]) o_count = CNT_W'(WIDTH - 1 - i);
        end
    end

endmodule

// File: rtl/fp_addsub_pipe.sv
// rtl/fp_addsub_pipe.sv - 3-stage flush-to-zero FP add/sub pipeline with global stall
// FP_ADDSUB_RNE_EN selects round-to-nearest-even; otherwise results are truncated.
module fp_addsub_pipe
    import fp_pkg::*;
#(
    parameter int EXP_W = EXP_W_DEF,
    parameter int MAN_W = MAN_W_DEF
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [EXP_W+MAN_W:0]   A,
    input  logic [EXP_W+MAN_W:0]   B,
    input  logic                   addsub,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [EXP_W+MAN_W:0]   result,
    output logic [2:0]             flags
);

    localparam int W       = 1 + EXP_W + MAN_W;
    localparam int M       = MAN_W + 1;
    localparam int E       = M + 3;
    localparam int SH_MAX  = MAN_W + 3;
    localparam int SHW     = $clog2(SH_MAX + 1);
    localparam int LZW     = $clog2(E + 1);
    localparam int XW      = EXP_W + 2;
    localparam int EXP_MAX = (1 << EXP_W) - 1;

    typedef struct packed {
        logic             sign;
        logic [EXP_W-1:0] exp;
        logic [M-1:0]     mant;
    } op_t;

    function automatic op_t unpack_op(input logic [W-1:0] x, input logic neg);
        op_t u;
        u.sign = x[W-1] ^ neg;
        u.exp  = x[W-2:MAN_W];
        u.mant = (x[W-2:MAN_W] == '0) ? '0 : {1'b1, x[MAN_W-1:0]};
        return u;
    endfunction

    logic             w_adv;
    op_t              w_a;
    op_t              w_b;
    op_t              w_big;
    op_t              w_small;
    logic             w_a_big;
    logic [EXP_W-1:0] w_diff;
    logic [SHW-1:0]   w_sh;
    logic [2*E-1:0]   w_wide;
    logic [E-1:0]     w_small_al;

    logic             r1_valid;
    logic             r1_sign;
    logic             r1_sub;
    logic [EXP_W-1:0] r1_exp;
    logic [E-1:0]     r1_big;
    logic [E-1:0]     r1_small;

    logic [E:0]       w_sum;
    logic             r2_valid;
    logic             r2_sign;
    logic [EXP_W-1:0] r2_exp;
    logic [E:0]       r2_sum;

    logic [LZW-1:0]   w_lz;
    logic [E-1:0]     w_norm;
    logic [XW-1:0]    w_nexp;
    logic             w_rup;
    logic [M:0]       w_rnd;
    logic [XW-1:0]    w_fexp;
    logic [MAN_W-1:0] w_fman;
    logic [W-1:0]     w_result;
    logic [2:0]       w_flags;
    logic             w_unused_grs;

    logic             r_out_valid;
    logic [W-1:0]     r_result;
    logic [2:0]       r_flags;

    assign w_adv     = !r_out_valid || out_ready;
    assign in_ready  = w_adv;
    assign out_valid = r_out_valid;
    assign result    = r_result;
    assign flags     = r_flags;

    // S1: magnitude order on raw {exp,man}, ties keep A as the larger operand.
    always_comb begin
        w_a        = unpack_op(A, 1'b0);
        w_b        = unpack_op(B, addsub);
        w_a_big    = (A[W-2:0] >= B[W-2:0]);
        w_big      = w_a_big ? w_a : w_b;
        w_small    = w_a_big ? w_b : w_a;
        w_diff     = w_big.exp - w_small.exp;
        w_sh       = (int'(w_diff) > SH_MAX) ? SHW'(SH_MAX) : SHW'(w_diff);
        w_wide     = {w_small.mant, 3'b000, {E{1'b0}}} >> w_sh;
        w_small_al = {w_wide[2*E-1:E+1], w_wide[E] | (|w_wide[E-1:0])};
    end

    // S2
    assign w_sum = r1_sub ? ({1'b0, r1_big} - {1'b0, r1_small})
                          : ({1'b0, r1_big} + {1'b0, r1_small});

    // S3
    fp_lzc #(
        .WIDTH (E),
        .CNT_W (LZW)
    ) u_lzc (
        .i_data  (r2_sum[E-1:0]),
        .o_count (w_lz)
    );

    always_comb begin
        if (r2_sum[E]) begin
            w_norm = {r2_sum[E:2], r2_sum[1] | r2_sum[0]};
            w_nexp = {2'b00, r2_exp} + XW'(1);
        end else begin
            w_norm = r2_sum[E-1:0] << w_lz;
            w_nexp = {2'b00, r2_exp} - XW'(w_lz);
        end
`ifdef FP_ADDSUB_RNE_EN
        w_rup = w_norm[2] & (w_norm[1] | w_norm[0] | w_norm[3]);
`else
        w_rup = 1'b0;
`endif
        w_rnd  = {1'b0, w_norm[E-1:3]} + (M+1)'(w_rup);
        w_fexp = w_nexp + XW'(w_rnd[M]);
        w_fman = w_rnd[M] ? w_rnd[MAN_W:1] : w_rnd[MAN_W-1:0];
    end

    assign w_unused_grs = ^w_norm[2:0];

    always_comb begin
        w_result = '0;
        w_flags  = '0;
        if (r2_sum == '0) begin
            w_flags[FLAG_ZERO] = 1'b1;
        end else if (!w_fexp[XW-1] && (w_fexp >= XW'(EXP_MAX))) begin
            w_result           = {r2_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
            w_flags[FLAG_OVF]  = 1'b1;
        end else if (w_fexp[XW-1] || (w_fexp == '0)) begin
            w_result           = {r2_sign, {(W-1){1'b0}}};
            w_flags[FLAG_UNF]  = 1'b1;
        end else begin
            w_result           = {r2_sign, w_fexp[EXP_W-1:0], w_fman};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r1_valid    <= 1'b0;
            r1_sign     <= 1'b0;
            r1_sub      <= 1'b0;
            r1_exp      <= '0;
            r1_big      <= '0;
            r1_small    <= '0;
            r2_valid    <= 1'b0;
            r2_sign     <= 1'b0;
            r2_exp      <= '0;
            r2_sum      <= '0;
            r_out_valid <= 1'b0;
            r_result    <= '0;
            r_flags     <= '0;
        end else if (w_adv) begin
            r1_valid    <= in_valid;
            r1_sign     <= w_big.sign;
            r1_sub      <= w_big.sign ^ w_small.sign;
            r1_exp      <= w_big.exp;
            r1_big      <= {w_big.mant, 3'b000};
            r1_small    <= w_small_al;
            r2_valid    <= r1_valid;
            r2_sign     <= r1_sign;
            r2_exp      <= r1_exp;
            r2_sum      <= w_sum;
            r_out_valid <= r2_valid;
            r_result    <= w_result;
            r_flags     <= w_flags;
        end
    end

endmodule

// File: tb/tb_fp_addsub_pipe.sv
// tb/tb_fp_addsub_pipe.sv - scoreboard bench for fp_addsub_pipe (honours FP_ADDSUB_RNE_EN)
module tb_fp_addsub_pipe;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        addsub = 1'b0;
    logic        out_ready = 1'b1;
    logic [31:0] A = '0;
    logic [31:0] B = '0;
    logic        in_ready;
    logic        out_valid;
    logic [31:0] result;
    logic [2:0]  flags;

    int compared = 0;
    int mismatched = 0;
    int cyc = 0;
    int n_out = 0;
    int n_mark = 0;

    typedef struct {
        logic [31:0] res;
        logic [2:0]  fl;
        int          acc;
        bit          lat;
    } exp_t;

    exp_t sb[$];
    exp_t e_m;

`ifdef FP_ADDSUB_RNE_EN
    localparam logic [31:0] R6 = 32'h3F800002;
`else
    localparam logic [31:0] R6 = 32'h3F800001;
`endif

    logic [31:0] va [13] = '{32'h3F800000, 32'h40400000, 32'h3F800000, 32'h3F800000,
                             32'h7F7FFFFF, 32'h3F800000, 32'h3F800000, 32'h00800000,
                             32'h80000000, 32'h7F800000, 32'hC0000000, 32'h40000000,
                             32'h3F800000};
    logic [31:0] vb [13] = '{32'h3F800000, 32'h3F800000, 32'h40400000, 32'h3F800000,
                             32'h7F7FFFFF, 32'h33800000, 32'h34400000, 32'h00C00000,
                             32'h80000000, 32'h00000000, 32'h40000000, 32'hBF800000,
                             32'h00400000};
    logic        vop [13] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1,
                              1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    logic [31:0] vr [13] = '{32'h40000000, 32'h40000000, 32'hC0000000, 32'h00000000,
                             32'h7F800000, 32'h3F800000, R6,           32'h80000000,
                             32'h00000000, 32'h7F800000, 32'h00000000, 32'h3F800000,
                             32'h3F800000};
    logic [2:0]  vf [13] = '{3'b000, 3'b000, 3'b000, 3'b001, 3'b100, 3'b000, 3'b000,
                             3'b010, 3'b001, 3'b100, 3'b001, 3'b000, 3'b000};

    fp_addsub_pipe dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .A         (A),
        .B         (B),
        .addsub    (addsub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .flags     (flags)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            n_out++;
            compared++;
            assert (sb.size() > 0) else begin
                mismatched++;
                $error("FAIL stale_output observed=%h expected=none", result);
            end
            if (sb.size() > 0) begin
                e_m = sb.pop_front();
                compared += 2;
                assert (result === e_m.res) else begin
                    mismatched++;
                    $error("FAIL result#%0d observed=%h expected=%h", n_out, result, e_m.res);
                end
                assert (flags === e_m.fl) else begin
                    mismatched++;
                    $error("FAIL flags#%0d observed=%b expected=%b", n_out, flags, e_m.fl);
                end
                if (e_m.lat) begin
                    compared++;
                    assert ((cyc - e_m.acc) == 3) else begin
                        mismatched++;
                        $error("FAIL latency#%0d observed=%0d expected=3", n_out, cyc - e_m.acc);
                    end
                end
            end
        end
    end

    task automatic send(input int i, input bit lat);
        int   g;
        exp_t e;
        @(negedge clk);
        A = va[i];
        B = vb[i];
        addsub = vop[i];
        in_valid = 1'b1;
        g = 0;
        while (!in_ready && g < 50) begin
            @(negedge clk);
            g++;
        end
        compared++;
        assert (in_ready === 1'b1) else begin
            mismatched++;
            $error("FAIL accept_timeout vec=%0d observed=%b expected=1", i, in_ready);
        end
        e.res = vr[i];
        e.fl  = vf[i];
        e.acc = cyc;
        e.lat = lat;
        if (in_ready) sb.push_back(e);
        @(posedge clk);
    endtask

    task automatic idle();
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic drain(input string tag);
        int g;
        g = 0;
        while (sb.size() != 0 && g < 60) begin
            @(negedge clk);
            g++;
        end
        compared++;
        assert (sb.size() == 0) else begin
            mismatched++;
            $error("FAIL drain_%s observed=%0d expected=0", tag, sb.size());
        end
    endtask

    task automatic check_reset_state(input string tag);
        compared += 4;
        assert (out_valid === 1'b0) else begin
            mismatched++;
            $error("FAIL %s_out_valid observed=%b expected=0", tag, out_valid);
        end
        assert (result === 32'h0) else begin
            mismatched++;
            $error("FAIL %s_result observed=%h expected=00000000", tag, result);
        end
        assert (flags === 3'b000) else begin
            mismatched++;
            $error("FAIL %s_flags observed=%b expected=000", tag, flags);
        end
        assert (in_ready === 1'b1) else begin
            mismatched++;
            $error("FAIL %s_in_ready observed=%b expected=1", tag, in_ready);
        end
    endtask

    initial begin
        // reset state
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_reset_state("reset");
        rst = 1'b0;

        // directed vectors, back-to-back, no stall: exact 3-cycle latency
        for (int i = 0; i < 13; i++) send(i, 1'b1);
        idle();
        drain("directed");

        // downstream stall for 5 cycles while operands keep coming
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        n_mark = n_out;
        fork
            begin
                for (int i = 0; i < 8; i++) send(i, 1'b0);
                idle();
            end
            begin : stall_ctl
                int g;
                g = 0;
                while (!out_valid && g < 20) begin
                    @(negedge clk);
                    g++;
                end
                for (int k = 0; k < 5; k++) begin
                    if (k > 0) @(negedge clk);
                    compared += 4;
                    assert (out_valid === 1'b1) else begin
                        mismatched++;
                        $error("FAIL stall_out_valid k=%0d observed=%b expected=1", k, out_valid);
                    end
                    assert (in_ready === 1'b0) else begin
                        mismatched++;
                        $error("FAIL stall_in_ready k=%0d observed=%b expected=0", k, in_ready);
                    end
                    assert (result === vr[0]) else begin
                        mismatched++;
                        $error("FAIL stall_hold_result k=%0d observed=%h expected=%h", k, result, vr[0]);
                    end
                    assert (flags === vf[0]) else begin
                        mismatched++;
                        $error("FAIL stall_hold_flags k=%0d observed=%b expected=%b", k, flags, vf[0]);
                    end
                end
                @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        drain("stall");
        compared++;
        assert ((n_out - n_mark) == 8) else begin
            mismatched++;
            $error("FAIL stall_count observed=%0d expected=8", n_out - n_mark);
        end

        // reset with three operations in flight
        send(3, 1'b0);
        send(4, 1'b0);
        send(5, 1'b0);
        #1;
        rst = 1'b1;
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        check_reset_state("midrst");
        sb.delete();
        rst = 1'b0;
        n_mark = n_out;
        repeat (10) @(negedge clk);
        compared++;
        assert (n_out == n_mark) else begin
            mismatched++;
            $error("FAIL midrst_stale observed=%0d expected=0", n_out - n_mark);
        end

        // recovery after reset
        send(11, 1'b1);
        idle();
        drain("recover");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
